// File: rtl/dataflow_host_ctrl.sv
// Host-side initiator for the ping-pong dataflow top: loads an A frame, kicks ap_start,
// serves A reads, captures F writes and streams the F frame out. Optional watchdog: HOST_TIMEOUT_EN.
module dataflow_host_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 5
`ifdef HOST_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 4096
`endif
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              dut_ap_start,
    input  logic              dut_ap_ready,
    input  logic              dut_ap_done,
    input  logic              dut_ap_idle,
    input  logic [ADDR_W-1:0] A_address0,
    input  logic              A_ce0,
    output logic [DATA_W-1:0] A_q0,
    input  logic [ADDR_W-1:0] F_address0,
    input  logic              F_ce0,
    input  logic              F_we0,
    input  logic [DATA_W-1:0] F_d0,
    output logic              busy,
    output logic              err,
    output logic [15:0]       frames_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                ap_start_q;
    logic                err_q;
    logic [ADDR_W-1:0]   wr_cnt_q;
    logic [ADDR_W-1:0]   rd_cnt_q;
    logic [15:0]         frames_q;
    logic [DATA_W-1:0]   a_q0_q;

    logic [DATA_W-1:0]   abuf [DEPTH];
    logic [DATA_W-1:0]   fbuf [DEPTH];

    logic                a_in_range;
    logic                f_in_range;
    logic                f_cap;
    logic                load_acc;
    logic                timeout_hit;
    logic                idle_unused;

    // ap_idle is informational only; the handshake is driven by ap_ready/ap_done
    assign idle_unused = dut_ap_idle;

    assign a_in_range = ({1'b0, A_address0} < DEPTH_C);
    assign f_in_range = ({1'b0, F_address0} < DEPTH_C);
    assign f_cap      = (state_q == S_START) || (state_q == S_RUN);
    assign load_acc   = (state_q == S_LOAD) && in_valid && in_ready_q;

`ifdef HOST_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wdog_q;

    assign timeout_hit = f_cap && (wdog_q == TO_LAST) && !dut_ap_done;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wdog_q <= '0;
        end else if (load_acc && (wr_cnt_q == LAST_C)) begin
            wdog_q <= '0;
        end else if (f_cap) begin
            wdog_q <= wdog_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Control FSM; every control output is a register set on the transition into its state
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ap_start_q  <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            frames_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_acc) begin
                        if (wr_cnt_q == LAST_C) begin
                            wr_cnt_q   <= '0;
                            in_ready_q <= 1'b0;
                            ap_start_q <= 1'b1;
                            state_q    <= S_START;
                        end else begin
                            wr_cnt_q <= wr_cnt_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (timeout_hit) begin
                        ap_start_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DRAIN;
                    end else if (dut_ap_ready) begin
                        ap_start_q <= 1'b0;
                        if (dut_ap_done) begin
                            out_valid_q <= 1'b1;
                            state_q     <= S_DRAIN;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (dut_ap_done || timeout_hit) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_cnt_q == LAST_C) begin
                            rd_cnt_q    <= '0;
                            frames_q    <= frames_q + 16'd1;
                            out_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            err_q <= 1'b0;
        end else if ((A_ce0 && !a_in_range) ||
                     (f_cap && F_ce0 && F_we0 && !f_in_range) ||
                     timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    // Read port registers old contents, so a same-cycle LOAD write is not forwarded
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            a_q0_q <= '0;
        end else if (A_ce0) begin
            a_q0_q <= a_in_range ? abuf[A_address0] : '0;
        end
    end

    // Buffers carry no reset; only the write strobes are qualified
    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && load_acc) begin
            abuf[wr_cnt_q] <= in_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst_n && f_cap && F_ce0 && F_we0 && f_in_range) begin
            fbuf[F_address0] <= F_d0;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_valid_q ? fbuf[rd_cnt_q] : '0;
    assign out_last     = out_valid_q && (rd_cnt_q == LAST_C);
    assign dut_ap_start = ap_start_q;
    assign A_q0         = a_q0_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;
    assign frames_done  = frames_q;

endmodule

// File: tb/tb_dataflow_host_ctrl.sv
// Scoreboard bench for dataflow_host_ctrl with a behavioural model of the dataflow top.
module tb_dataflow_host_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 5;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          dut_ap_start;
    logic          dut_ap_ready = 1'b0;
    logic          dut_ap_done = 1'b0;
    logic          dut_ap_idle = 1'b1;
    logic [AW-1:0] A_address0 = '0;
    logic          A_ce0 = 1'b0;
    logic [DW-1:0] A_q0;
    logic [AW-1:0] F_address0 = '0;
    logic          F_ce0 = 1'b0;
    logic          F_we0 = 1'b0;
    logic [DW-1:0] F_d0 = '0;
    logic          busy;
    logic          err;
    logic [15:0]   frames_done;

    dataflow_host_ctrl dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .dut_ap_start(dut_ap_start), .dut_ap_ready(dut_ap_ready), .dut_ap_done(dut_ap_done),
        .dut_ap_idle(dut_ap_idle),
        .A_address0(A_address0), .A_ce0(A_ce0), .A_q0(A_q0),
        .F_address0(F_address0), .F_ce0(F_ce0), .F_we0(F_we0), .F_d0(F_d0),
        .busy(busy), .err(err), .frames_done(frames_done)
    );

    always #5 ap_clk = ~ap_clk;

    int            n_tests = 0;
    int            n_fail = 0;
    int            n_hs = 0;
    int            mon_idx = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] frm[DEPTH];
    logic [15:0]   frames_exp = '0;
    logic          err_exp = 1'b0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic          held_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: compares each handshake against the scoreboard, checks stall stability
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            mon_idx    = 0;
            stall_prev = 1'b0;
        end else if (out_valid) begin
            if (stall_prev) begin
                chk("hold_data", out_data, held_data);
                chk("hold_last", out_last, held_last);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h expected no word", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    chk("out_last", out_last, (mon_idx == DEPTH - 1));
                    mon_idx = (mon_idx == DEPTH - 1) ? 0 : mon_idx + 1;
                    n_hs++;
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                held_data  = out_data;
                held_last  = out_last;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // mode 0: nominal, 1: out-of-range access + ready/done together,
    // 2: reset while in RUN, 3: reset while in START
    task automatic run_frame(input int mode, input int bp);
        int            i, guard, ready_t, done_t, abort_t, hs0;
        bit            acc;
        logic [DW-1:0] rd[DEPTH];
        i = 0;
        guard = 0;
        while (i < DEPTH && guard < 300) begin
            in_data  = frm[i];
            in_valid = ($urandom_range(0, 3) != 0);
            acc      = in_valid && in_ready;
            @(posedge ap_clk); #1;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        chk("load_words", i, DEPTH);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(frm[k] * 32'd2);

        ready_t = (mode == 1) ? 14 : 1;
        done_t  = (mode == 1) ? 14 : (mode >= 2 ? 1000 : 21);
        abort_t = (mode == 2) ? 5 : 1;
        for (int t = 0; t <= done_t; t++) begin
            if (mode >= 2 && t == abort_t) break;
            chk("ap_start", dut_ap_start, (t <= ready_t));
            if (t == 0) chk("busy_start", busy, 1);
            if (t >= 1 && t <= DEPTH) begin
                chk("A_q0", A_q0, frm[t-1]);
                rd[t-1] = A_q0;
            end
            if (t == 7) chk("A_q0_hold", A_q0, frm[DEPTH-1]);
            if (mode == 1 && t == 12) chk("A_q0_oob", A_q0, 0);
            if (mode == 1 && t == 13) chk("err_oob", err, 1);
            A_ce0      = (t < DEPTH) || (mode == 1 && t == 11);
            A_address0 = (t < DEPTH) ? 3'(t) : ((mode == 1 && t == 11) ? 3'd5 : 3'($urandom));
            F_ce0      = (t >= 6 && t < 6 + DEPTH) || (t == 11);
            F_we0      = (t >= 6 && t < 6 + DEPTH) || (mode == 1 && t == 11);
            F_address0 = (t >= 6 && t < 6 + DEPTH) ? 3'(t - 6) : ((mode == 1) ? 3'd7 : 3'd0);
            F_d0       = (t >= 6 && t < 6 + DEPTH) ? rd[t-6] * 32'd2 : 32'hDEAD_BEEF;
            dut_ap_ready = (t == ready_t);
            dut_ap_done  = (t == done_t);
            @(posedge ap_clk); #1;
        end
        A_ce0 = 1'b0; F_ce0 = 1'b0; F_we0 = 1'b0;
        dut_ap_ready = 1'b0; dut_ap_done = 1'b0;

        if (mode >= 2) begin
            chk("busy_before_abort", busy, 1);
            ap_rst_n = 1'b0;
            @(posedge ap_clk); #1;
            chk("abort_ap_start", dut_ap_start, 0);
            chk("abort_busy", busy, 0);
            chk("abort_frames", frames_done, 0);
            chk("abort_err", err, 0);
            chk("abort_out_valid", out_valid, 0);
            chk("abort_in_ready", in_ready, 0);
            ap_rst_n = 1'b1;
            exp_q.delete();
            frames_exp = '0;
            err_exp = 1'b0;
        end else begin
            chk("ap_start_run", dut_ap_start, 0);
            hs0 = n_hs;
            guard = 0;
            while (exp_q.size() != 0 && guard < 200) begin
                case (bp)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (guard % 4 == 0) || (guard % 4 == 3);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                @(posedge ap_clk); #1;
                guard++;
            end
            out_ready = 1'b0;
            frames_exp++;
            chk("handshakes", n_hs - hs0, DEPTH);
            chk("frames_done", frames_done, frames_exp);
            chk("err", err, err_exp);
            chk("out_valid_end", out_valid, 0);
            chk("busy_end", busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        in_valid = 1'b1;
        in_data  = 32'h11;
        repeat (3) begin
            @(posedge ap_clk); #1;
            chk("rst_ctrl", {in_ready, out_valid, out_last, dut_ap_start, busy, err}, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_A_q0", A_q0, 0);
            chk("rst_frames", frames_done, 0);
        end
        ap_rst_n = 1'b1;
        chk("idle_in_ready", in_ready, 0);
        @(posedge ap_clk); #1;
        chk("load_in_ready", in_ready, 1);
        in_valid = 1'b0;

        for (int k = 0; k < DEPTH; k++) frm[k] = 32'(k + 1);
        run_frame(0, 0);

        for (int k = 0; k < DEPTH; k++) frm[k] = $urandom;
        run_frame(0, 1);

        for (int k = 0; k < DEPTH; k++) frm[k] = $urandom;
        err_exp = 1'b1;
        run_frame(1, 0);

        repeat (2) begin
            for (int k = 0; k < DEPTH; k++) frm[k] = $urandom;
            run_frame(0, 2);
        end

        for (int k = 0; k < DEPTH; k++) frm[k] = $urandom;
        run_frame(2, 0);
        for (int k = 0; k < DEPTH; k++) frm[k] = $urandom;
        run_frame(3, 0);

        for (int k = 0; k < DEPTH; k++) frm[k] = $urandom;
        run_frame(0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
